// File: rtl/load_writeback_buffer.sv
// Load result buffer between the load unit and writeback.
// Circular FIFO of {data, address, packet} entries with flush support.
//
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   flush_i                  drop every buffered entry
//   ldu_data_valid_i/_data_i/_address_i/_packet_i   load unit result
//   ldu_data_accepted_o      result taken this cycle
//   wb_valid_o/_data_o/_address_o/_packet_o         head entry
//   wb_ready_i               writeback consumes the head entry
//   count_o, full_o, empty_o occupancy

package core_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
    } instr_packet_t;
endpackage

module load_writeback_buffer
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     ldu_data_valid_i,
    input  logic [XLEN-1:0]          ldu_data_i,
    input  logic [XLEN-1:0]          ldu_address_i,
    input  instr_packet_t            ldu_packet_i,
    output logic                     ldu_data_accepted_o,
    output logic                     wb_valid_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic [XLEN-1:0]          wb_address_o,
    output instr_packet_t            wb_packet_o,
    input  logic                     wb_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];
    instr_packet_t    pkt_q  [DEPTH];

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             push;
    logic             pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

    assign push = ldu_data_valid_i & ~full_o & ~flush_i;
    assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

    assign ldu_data_accepted_o = push;
    assign wb_valid_o          = ~empty_o;

    // Head is masked to zero when empty so stale storage never leaks.
    assign wb_data_o    = wb_valid_o ? data_q[rd_ptr_q] : '0;
    assign wb_address_o = wb_valid_o ? addr_q[rd_ptr_q] : '0;
    assign wb_packet_o  = wb_valid_o ? pkt_q[rd_ptr_q]  : '0;

    // Storage is deliberately left unreset; the count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= ldu_data_i;
            addr_q[wr_ptr_q] <= ldu_address_i;
            pkt_q[wr_ptr_q]  <= ldu_packet_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_load_writeback_buffer.sv
// Directed testbench for load_writeback_buffer.
// One task per scenario, hand-computed expectations.

module tb_load_writeback_buffer;
    import core_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          ldu_data_valid_i;
    logic [31:0]   ldu_data_i;
    logic [31:0]   ldu_address_i;
    instr_packet_t ldu_packet_i;
    logic          ldu_data_accepted_o;
    logic          wb_valid_o;
    logic [31:0]   wb_data_o;
    logic [31:0]   wb_address_o;
    instr_packet_t wb_packet_o;
    logic          wb_ready_i;
    logic [2:0]    count_o;
    logic          full_o;
    logic          empty_o;

    int n_chk  = 0;
    int n_fail = 0;

    load_writeback_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .flush_i             (flush_i),
        .ldu_data_valid_i    (ldu_data_valid_i),
        .ldu_data_i          (ldu_data_i),
        .ldu_address_i       (ldu_address_i),
        .ldu_packet_i        (ldu_packet_i),
        .ldu_data_accepted_o (ldu_data_accepted_o),
        .wb_valid_o          (wb_valid_o),
        .wb_data_o           (wb_data_o),
        .wb_address_o        (wb_address_o),
        .wb_packet_o         (wb_packet_o),
        .wb_ready_i          (wb_ready_i),
        .count_o             (count_o),
        .full_o              (full_o),
        .empty_o             (empty_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled 1 unit later, well before the next edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_in(input logic [31:0] d);
        ldu_data_valid_i = 1'b1;
        ldu_data_i       = d;
        ldu_address_i    = 32'h200 + d;
        ldu_packet_i     = '{pc: 32'h1000 + d, rd: 5'd1, rd_we: 1'b1};
    endtask

    task automatic test_reset();
        rst_n_i          = 1'b0;
        flush_i          = 1'b0;
        wb_ready_i       = 1'b1;
        push_in(32'h55);
        #3;
        n_chk++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b exp 0", wb_valid_o); end
        n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count_o); end
        n_chk++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin n_fail++; $display("FAIL rst_flags got e%0b f%0b exp e1 f0", empty_o, full_o); end
        n_chk++; if (wb_data_o !== 32'h0 || wb_address_o !== 32'h0 || wb_packet_o !== '0) begin n_fail++; $display("FAIL rst_head got %h/%h exp 0/0", wb_data_o, wb_address_o); end
        n_chk++; if (ldu_data_accepted_o !== 1'b1) begin n_fail++; $display("FAIL rst_accept got %0b exp 1", ldu_data_accepted_o); end
        ldu_data_valid_i = 1'b0;
        wb_ready_i       = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_empty got %0b exp 1", empty_o); end
    endtask

    task automatic test_single();
        ldu_data_valid_i = 1'b1;
        ldu_data_i       = 32'hFFFF_FF80;
        ldu_address_i    = 32'h100;
        ldu_packet_i     = '{pc: 32'h8000_0004, rd: 5'd7, rd_we: 1'b1};
        wb_ready_i       = 1'b1;
        #1;
        n_chk++; if (ldu_data_accepted_o !== 1'b1) begin n_fail++; $display("FAIL single_accept got %0b exp 1", ldu_data_accepted_o); end
        n_chk++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_nobypass got %0b exp 0", wb_valid_o); end
        tick();
        ldu_data_valid_i = 1'b0;
        #1;
        n_chk++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF_FF80 || wb_address_o !== 32'h100) begin n_fail++; $display("FAIL single_head got v%0b %h %h exp v1 ffffff80 00000100", wb_valid_o, wb_data_o, wb_address_o); end
        n_chk++; if (wb_packet_o.pc !== 32'h8000_0004 || wb_packet_o.rd !== 5'd7) begin n_fail++; $display("FAIL single_pkt got %h %0d exp 80000004 7", wb_packet_o.pc, wb_packet_o.rd); end
        tick();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL single_empty got %0b exp 1", empty_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'd3, 32'd4, 32'd5};
        wb_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_in(32'(i));
            #1;
            n_chk++; if (ldu_data_accepted_o !== 1'b1) begin n_fail++; $display("FAIL fill_accept%0d got %0b exp 1", i, ldu_data_accepted_o); end
            tick();
        end
        push_in(32'd5);
        #1;
        n_chk++; if (full_o !== 1'b1 || count_o !== 3'd4) begin n_fail++; $display("FAIL fill_full got f%0b c%0d exp f1 c4", full_o, count_o); end
        n_chk++; if (ldu_data_accepted_o !== 1'b0) begin n_fail++; $display("FAIL fill_refuse got %0b exp 0", ldu_data_accepted_o); end
        tick();
        n_chk++; if (count_o !== 3'd4 || wb_data_o !== 32'd1) begin n_fail++; $display("FAIL fill_hold got c%0d d%0d exp c4 d1", count_o, wb_data_o); end
        n_chk++; if (wb_address_o !== 32'h201) begin n_fail++; $display("FAIL fill_hold_addr got %h exp 00000201", wb_address_o); end
        wb_ready_i = 1'b1;
        #1;
        n_chk++; if (ldu_data_accepted_o !== 1'b0 || wb_data_o !== 32'd1) begin n_fail++; $display("FAIL fill_popfull got a%0b d%0d exp a0 d1", ldu_data_accepted_o, wb_data_o); end
        tick();
        n_chk++; if (ldu_data_accepted_o !== 1'b1 || wb_data_o !== 32'd2) begin n_fail++; $display("FAIL fill_fifth got a%0b d%0d exp a1 d2", ldu_data_accepted_o, wb_data_o); end
        tick();
        ldu_data_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (wb_valid_o !== 1'b1 || wb_data_o !== exp_seq[i]) begin n_fail++; $display("FAIL fill_order%0d got v%0b d%0d exp v1 d%0d", i, wb_valid_o, wb_data_o, exp_seq[i]); end
            tick();
        end
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fill_drained got %0b exp 1", empty_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_simul();
        wb_ready_i = 1'b0;
        push_in(32'h11); tick();
        push_in(32'h22); tick();
        push_in(32'h33);
        wb_ready_i = 1'b1;
        #1;
        n_chk++; if (count_o !== 3'd2 || ldu_data_accepted_o !== 1'b1 || wb_data_o !== 32'h11) begin n_fail++; $display("FAIL simul_pre got c%0d a%0b d%h exp c2 a1 d11", count_o, ldu_data_accepted_o, wb_data_o); end
        tick();
        ldu_data_valid_i = 1'b0;
        #1;
        n_chk++; if (count_o !== 3'd2 || wb_data_o !== 32'h22) begin n_fail++; $display("FAIL simul_post got c%0d d%h exp c2 d22", count_o, wb_data_o); end
        tick();
        n_chk++; if (wb_data_o !== 32'h33) begin n_fail++; $display("FAIL simul_tail got %h exp 33", wb_data_o); end
        tick();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL simul_empty got %0b exp 1", empty_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_in(32'h40 + 32'(i));
            tick();
        end
        push_in(32'h4F);
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        #1;
        n_chk++; if (count_o !== 3'd3 || ldu_data_accepted_o !== 1'b0) begin n_fail++; $display("FAIL flush_accept got c%0d a%0b exp c3 a0", count_o, ldu_data_accepted_o); end
        tick();
        flush_i          = 1'b0;
        ldu_data_valid_i = 1'b0;
        wb_ready_i       = 1'b0;
        #1;
        n_chk++; if (count_o !== 3'd0 || wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_clear got c%0d v%0b exp c0 v0", count_o, wb_valid_o); end
        push_in(32'h77);
        tick();
        ldu_data_valid_i = 1'b0;
        wb_ready_i       = 1'b1;
        #1;
        n_chk++; if (count_o !== 3'd1 || wb_data_o !== 32'h77) begin n_fail++; $display("FAIL flush_after got c%0d d%h exp c1 d77", count_o, wb_data_o); end
        tick();
        wb_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_in(32'hA0 + 32'(i));
            #1;
            n_chk++; if (ldu_data_accepted_o !== 1'b1) begin n_fail++; $display("FAIL wrap_accept%0d got %0b exp 1", i, ldu_data_accepted_o); end
            if (i > 0) begin
                n_chk++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hA0 + 32'(i - 1)) begin n_fail++; $display("FAIL wrap_out%0d got v%0b d%h exp v1 d%h", i, wb_valid_o, wb_data_o, 32'hA0 + 32'(i - 1)); end
            end
            tick();
        end
        ldu_data_valid_i = 1'b0;
        #1;
        n_chk++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hA9) begin n_fail++; $display("FAIL wrap_last got v%0b d%h exp v1 a9", wb_valid_o, wb_data_o); end
        tick();
        n_chk++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %0b exp 1", empty_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        wb_ready_i = 1'b0;
        push_in(32'hC1); tick();
        push_in(32'hC2); tick();
        ldu_data_valid_i = 1'b0;
        #1;
        n_chk++; if (count_o !== 3'd2 || wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre got c%0d v%0b exp c2 v1", count_o, wb_valid_o); end
        rst_n_i = 1'b0;
        #1;
        n_chk++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0 || wb_data_o !== 32'h0) begin n_fail++; $display("FAIL arst_drop got v%0b c%0d d%h exp v0 c0 d0", wb_valid_o, count_o, wb_data_o); end
        tick();
        #2;
        rst_n_i = 1'b1;
        tick();
        n_chk++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL arst_post got c%0d e%0b exp c0 e1", count_o, empty_o); end
        push_in(32'hD5);
        tick();
        ldu_data_valid_i = 1'b0;
        #1;
        n_chk++; if (count_o !== 3'd1 || wb_data_o !== 32'hD5) begin n_fail++; $display("FAIL arst_fresh got c%0d d%h exp c1 dd5", count_o, wb_data_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_writeback_buffer.md
LOAD_WRITEBACK_BUFFER -- requirements
Module: load_writeback_buffer

Interface
REQ-001 Parameter: XLEN, default 32, data and address width.
REQ-002 Parameter: DEPTH, default 4, number of entries; power of two, 2 to 16.
REQ-003 clk_i  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  pipeline flush; discards all buffered entries.
REQ-006 ldu_data_valid_i  input  1  load unit holds a completed load result.
REQ-007 ldu_data_i  input  XLEN  extended load result from the load unit.
REQ-008 ldu_address_i  input  XLEN  effective address of the load.
REQ-009 ldu_packet_i  input  instr_packet_t  instruction packet of the load.
REQ-010 ldu_data_accepted_o  output  1  result taken this cycle; the load unit returns to idle.
REQ-011 wb_valid_o  output  1  head entry is presented to writeback.
REQ-012 wb_data_o  output  XLEN  head entry data.
REQ-013 wb_address_o  output  XLEN  head entry address.
REQ-014 wb_packet_o  output  instr_packet_t  head entry packet.
REQ-015 wb_ready_i  input  1  writeback consumes the head entry this cycle.
REQ-016 count_o  output  $clog2(DEPTH)+1  number of valid entries.
REQ-017 full_o / empty_o  output  1 each  count_o == DEPTH / count_o == 0.

Function
REQ-018 Storage: circular FIFO of DEPTH entries {data, address, packet}; write pointer, read pointer and count registers; pointers wrap from DEPTH-1 to 0.
REQ-019 Push condition: ldu_data_valid_i & !full_o & !flush_i; the entry is written at the write pointer and the write pointer advances.
REQ-020 ldu_data_accepted_o = ldu_data_valid_i & !full_o & !flush_i; purely combinational and asserted only in the push cycle.
REQ-021 Pop condition: wb_valid_o & wb_ready_i & !flush_i; the read pointer advances.
REQ-022 wb_valid_o = !empty_o. The head fields come from the entry at the read pointer. When empty, the head fields are driven to 0.
REQ-023 Latency: an entry pushed in cycle N is presented on wb_* in cycle N+1 at the earliest; there is no same-cycle bypass.
REQ-024 Push and pop in the same cycle: both take effect and count_o is unchanged. This is legal when count_o is between 1 and DEPTH-1.
REQ-025 Full: the push is refused (accepted_o=0) even if a pop occurs in the same cycle; the push succeeds the next cycle.
REQ-026 Empty: wb_ready_i is ignored and nothing is popped.
REQ-027 Flush: pointers and count are cleared at the next edge. Any push or pop in the flush cycle is discarded, and accepted_o=0 in that cycle.
REQ-028 Order: entries leave in exactly the order they were accepted; no entry is duplicated or lost except by flush.
REQ-029 Outputs must hold stable while wb_valid_o=1 and wb_ready_i=0.

Reset
REQ-030 On rst_n_i low, the pointers and count clear asynchronously.
REQ-031 While reset is asserted: wb_valid_o=0, wb_data_o/wb_address_o/wb_packet_o=0, count_o=0, empty_o=1, full_o=0.
REQ-032 During reset, ldu_data_accepted_o follows REQ-020 with count 0.
REQ-033 Storage arrays are not reset.
REQ-034 Reset asserted mid-operation discards all entries; the first edge after deassertion behaves as from empty.

Verification
REQ-035 Single load: ldu_data_valid_i=1, data 0xFFFFFF80, address 0x100, wb_ready_i=1.
- Required response: accepted_o=1 in cycle 0.
- Cycle 1: wb_valid_o=1, wb_data_o=0xFFFFFF80, wb_address_o=0x100.
- Cycle 2: empty_o=1.
REQ-036 Fill with wb_ready_i=0: push data 1..5 with DEPTH=4.
- Required response: the first four are accepted, then full_o=1, count_o=4.
- The fifth has accepted_o=0 and is held.
- On wb_ready_i=1, the fifth is accepted one cycle after the first pop.
- Output order is 1,2,3,4,5.
REQ-037 Simultaneous push/pop with count 2: count stays 2 and the head advances to the next entry.
REQ-038 Flush with count 3 plus a concurrent push: accepted_o=0; the next cycle count_o=0 and wb_valid_o=0.
REQ-039 Wrap: 10 back-to-back pushes of 0xA0+i with wb_ready_i=1 throughout.
- Required response: the output sequence is 0xA0..0xA9, with no gaps after the first.
REQ-040 Asynchronous reset asserted between edges with count 2: wb_valid_o falls immediately; after release, count_o=0.
